dispatch_ctrl: RTL and testbench
================================

Name: dispatch_ctrl

Overview:
- Sequencing controller wrapped around the combinational pair scheduler (fetch_data in; instr1/instr2/write1/write2/jal/jal_addr out).
- Holds one fetched instruction pair, presents it to the scheduler and issues the result to the backend over a valid/ready handshake.
- Splits dependent or load/store pairs across two issue cycles and raises a front-end redirect on JAL.
- Applies a fetch bubble after each redirect so wrong-path fetches are dropped.

Parameters:
- BUBBLE_CYC, 2, cycles fetch_ready is held low after a redirect (0 = no bubble; legal range 0..15).
- CNT_W, 32, width of the statistics counters (see Optional Feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  backend mispredict flush, synchronous, highest priority.
- fetch_valid  in  1  fetch pair valid.
- fetch_data  in  128  pair: [31:0] pc0, [63:32] ins0, [95:64] pc1, [127:96] ins1.
- fetch_ready  out  1  controller accepts the pair this cycle.
- sch_fetch_data  out  128  held pair, driven to the scheduler.
- sch_instr1  in  128  scheduler instr1.
- sch_instr2  in  128  scheduler instr2.
- sch_write1  in  1  scheduler write1.
- sch_write2  in  1  scheduler write2.
- sch_jal  in  1  scheduler jal.
- sch_jal_addr  in  32  scheduler jal_addr.
- issue_valid  out  1  issue bundle valid.
- issue_ready  in  1  backend accepts the bundle.
- issue_data  out  128  bundle: slot0 in [63:0], slot1 in [127:64], each slot {instr, pc}.
- issue_dual  out  1  both slots valid.
- redirect  out  1  one-cycle front-end redirect pulse.
- redirect_pc  out  32  redirect target; 0 when redirect is 0.

Behaviour:
- States: EMPTY, HOLD, SPLIT, BUBBLE. Registers: hold_reg[127:0], second_reg[63:0], bub_cnt[3:0].
- Reset (rst_n low, async): state EMPTY, all registers 0. While rst_n is low: fetch_ready=0, issue_valid=0, issue_dual=0, issue_data=0, redirect=0, redirect_pc=0.
- sch_fetch_data = hold_reg in every state.
- Acceptance: fetch_valid & fetch_ready loads hold_reg and moves to HOLD on the next edge.
- EMPTY: fetch_ready=1; issue_valid=0.
- HOLD decode (scheduler outputs are stable for the whole HOLD period):
  - J1 (sch_jal & !sch_write1): no issue; redirect=1 and redirect_pc=sch_jal_addr this cycle. Next state BUBBLE with bub_cnt=BUBBLE_CYC-1, or EMPTY if BUBBLE_CYC=0.
  - J2 (sch_jal & sch_write1): issue_valid=1, issue_dual=0, issue_data=sch_instr1. On handshake, redirect=1 and redirect_pc=sch_jal_addr in the same cycle, then BUBBLE/EMPTY as for J1.
  - SPL (sch_write2): issue_valid=1, issue_dual=0, issue_data=sch_instr1. On handshake, second_reg<=sch_instr2[63:0] and next state is SPLIT.
  - DUAL (sch_write1 & !sch_jal): issue_valid=1, issue_dual=1, issue_data=sch_instr1. On handshake, next state is EMPTY, or HOLD if a new pair is accepted in the same cycle.
- SPLIT: issue_valid=1, issue_dual=0, issue_data={64'd0, second_reg}. On handshake, next state is EMPTY, or HOLD if a pair is accepted in the same cycle.
- fetch_ready = !flush & (EMPTY | (HOLD & DUAL & handshake) | (SPLIT & handshake)). It depends combinationally on issue_ready; back-to-back pairs sustain one bundle per cycle.
- BUBBLE: fetch_ready=0, issue_valid=0. bub_cnt decrements each cycle; at 0, next state is EMPTY. A redirect costs exactly BUBBLE_CYC dead fetch cycles.
- issue_ready=0: issue_data, issue_dual and issue_valid stay stable; redirect is not raised for J2 until the handshake.
- flush=1: in the same cycle force issue_valid=0, redirect=0, fetch_ready=0. Next state EMPTY; hold_reg, second_reg and bub_cnt are cleared. Flush overrides a simultaneous handshake, so no transfer counts.
- rst_n asserted mid-operation discards all pending state immediately.

Optional Feature:
- Macro DISPATCH_STATS_EN.
- When defined: adds output ports cnt_dual, cnt_single, cnt_split, cnt_redirect, each CNT_W wide.
  - cnt_dual: +1 per dual-issue handshake.
  - cnt_single: +1 per single-issue handshake, including both halves of a split.
  - cnt_split: +1 per SPL handshake from HOLD.
  - cnt_redirect: +1 per redirect pulse.
  - Counters wrap modulo 2^CNT_W, reset to 0 by rst_n, and are not cleared by flush.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Independent pair {pc0=0x100 ins0=0x00100093, pc1=0x104 ins1=0x00300193}, issue_ready=1 -> one cycle after accept: issue_valid=1, issue_dual=1, issue_data={0x00300193,0x104,0x00100093,0x100}; state EMPTY next.
- RAW pair ins0=0x00100093 (addi x1), ins1=0x00108133 (add x2,x1,x1) -> two consecutive single issues: pc 0x100, then pc 0x104. fetch_ready=0 in the first issue cycle and 1 in the second.
- Load/store pair ins0=0x00002283, ins1=0x00002223 -> split into two single bundles; cnt_split=1 when DISPATCH_STATS_EN is defined.
- ins0=0x0080006F at pc0=0x200 -> no issue; redirect=1 with redirect_pc=0x208 for one cycle; fetch_ready=0 for exactly BUBBLE_CYC=2 cycles; fetch_valid during the bubble is ignored.
- ins1=0x0080006F at pc1=0x204, ins0 independent, issue_ready held 0 for 3 cycles -> bundle stable, no redirect. On the handshake cycle, redirect=1 with redirect_pc=0x20C.
- In SPLIT with issue_ready=0, assert flush together with issue_ready=1 -> no transfer; EMPTY on the next cycle; fetch_ready=1 after that; counters unchanged.

Source files
------------

// File: rtl/dispatch_ctrl.sv
`default_nettype none
//============================================================================
// Module   : dispatch_ctrl
// Purpose  : Sequencing controller around the combinational pair scheduler.
//            Holds one fetched instruction pair, presents it to the
//            scheduler, and issues the result to the backend over a
//            valid/ready handshake. Dependent or load/store pairs are split
//            across two issue cycles. A JAL raises a one-cycle front-end
//            redirect followed by a fetch bubble of BUBBLE_CYC cycles.
// Ports    : clk, rst_n (async, active low), flush (sync backend flush)
//            fetch_valid/fetch_data/fetch_ready   : fetch-side handshake
//            sch_fetch_data -> scheduler; sch_*  <- scheduler results
//            issue_valid/issue_ready/issue_data/issue_dual : backend issue
//            redirect/redirect_pc                 : front-end redirect
//            cnt_dual/cnt_single/cnt_split/cnt_redirect : statistics
//            (present only when DISPATCH_STATS_EN is defined)
// Options  : DISPATCH_STATS_EN - adds the CNT_W-wide statistics counters.
// Revision : 1.0 - initial release
//============================================================================
module dispatch_ctrl #(
    parameter int BUBBLE_CYC = 2,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 fetch_valid,
    input  logic [127:0]         fetch_data,
    output logic                 fetch_ready,
    output logic [127:0]         sch_fetch_data,
    input  logic [127:0]         sch_instr1,
    input  logic [127:0]         sch_instr2,
    input  logic                 sch_write1,
    input  logic                 sch_write2,
    input  logic                 sch_jal,
    input  logic [31:0]          sch_jal_addr,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [127:0]         issue_data,
    output logic                 issue_dual,
    output logic                 redirect,
    output logic [31:0]          redirect_pc
`ifdef DISPATCH_STATS_EN
    ,
    output logic [CNT_W-1:0]     cnt_dual,
    output logic [CNT_W-1:0]     cnt_single,
    output logic [CNT_W-1:0]     cnt_split,
    output logic [CNT_W-1:0]     cnt_redirect
`endif
);

    localparam logic [1:0] c_st_empty  = 2'd0;
    localparam logic [1:0] c_st_hold   = 2'd1;
    localparam logic [1:0] c_st_split  = 2'd2;
    localparam logic [1:0] c_st_bubble = 2'd3;

    // Counter preload so that BUBBLE lasts exactly BUBBLE_CYC cycles.
    localparam logic [3:0] c_bub_init  = (BUBBLE_CYC == 0) ? 4'd0 : 4'(BUBBLE_CYC - 1);
    // Where a redirect leads: straight back to EMPTY when no bubble is wanted.
    localparam logic [1:0] c_st_after_jal = (BUBBLE_CYC == 0) ? c_st_empty : c_st_bubble;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [127:0] r_hold;
    logic [63:0]  r_second;
    logic [3:0]   r_bub_cnt;

    logic w_j1, w_j2, w_spl, w_dual;
    logic w_hs, w_accept;
    logic w_jal_redirect;
    logic w_spl_hs;

    // Scheduler result classes. JAL wins over split/dual; a split request
    // wins over a plain dual issue.
    assign w_j1   = sch_jal & ~sch_write1;
    assign w_j2   = sch_jal &  sch_write1;
    assign w_spl  = ~sch_jal & sch_write2;
    assign w_dual = ~sch_jal & sch_write1 & ~sch_write2;

    // issue_valid and fetch_ready are already gated by flush and rst_n.
    assign w_hs     = issue_valid & issue_ready;
    assign w_accept = fetch_valid & fetch_ready;

    assign w_jal_redirect = (r_state == c_st_hold) & (w_j1 | (w_j2 & w_hs));
    assign w_spl_hs       = (r_state == c_st_hold) & w_spl & w_hs;

    assign sch_fetch_data = r_hold;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty: begin
                if (w_accept) w_state_nxt = c_st_hold;
            end
            c_st_hold: begin
                if (w_j1 || (w_j2 && w_hs)) begin
                    w_state_nxt = c_st_after_jal;
                end else if (w_spl && w_hs) begin
                    w_state_nxt = c_st_split;
                end else if (w_dual && w_hs) begin
                    w_state_nxt = w_accept ? c_st_hold : c_st_empty;
                end
            end
            c_st_split: begin
                if (w_hs) w_state_nxt = w_accept ? c_st_hold : c_st_empty;
            end
            c_st_bubble: begin
                if (r_bub_cnt == 4'd0) w_state_nxt = c_st_empty;
            end
            default: w_state_nxt = c_st_empty;
        endcase
        if (flush) w_state_nxt = c_st_empty;
    end

    // Output logic. Everything is forced quiet while in reset or flushing.
    always_comb begin
        fetch_ready = 1'b0;
        issue_valid = 1'b0;
        issue_dual  = 1'b0;
        issue_data  = 128'd0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        if (rst_n && !flush) begin
            case (r_state)
                c_st_empty: begin
                    fetch_ready = 1'b1;
                end
                c_st_hold: begin
                    if (w_j1) begin
                        redirect    = 1'b1;
                        redirect_pc = sch_jal_addr;
                    end else if (w_j2) begin
                        issue_valid = 1'b1;
                        issue_data  = sch_instr1;
                        // Redirect only once the slot ahead of the JAL is taken.
                        if (issue_ready) begin
                            redirect    = 1'b1;
                            redirect_pc = sch_jal_addr;
                        end
                    end else if (w_spl) begin
                        issue_valid = 1'b1;
                        issue_data  = sch_instr1;
                    end else if (w_dual) begin
                        issue_valid = 1'b1;
                        issue_dual  = 1'b1;
                        issue_data  = sch_instr1;
                        fetch_ready = issue_ready;
                    end
                end
                c_st_split: begin
                    issue_valid = 1'b1;
                    issue_data  = {64'd0, r_second};
                    fetch_ready = issue_ready;
                end
                default: begin
                end
            endcase
        end
    end

    // Data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold    <= 128'd0;
            r_second  <= 64'd0;
            r_bub_cnt <= 4'd0;
        end else if (flush) begin
            r_hold    <= 128'd0;
            r_second  <= 64'd0;
            r_bub_cnt <= 4'd0;
        end else begin
            if (w_accept) r_hold <= fetch_data;
            if (w_spl_hs) r_second <= sch_instr2[63:0];
            if (w_jal_redirect) begin
                r_bub_cnt <= c_bub_init;
            end else if ((r_state == c_st_bubble) && (r_bub_cnt != 4'd0)) begin
                r_bub_cnt <= r_bub_cnt - 4'd1;
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    // Statistics survive flush; a flushed cycle has no handshake or redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_dual     <= '0;
            cnt_single   <= '0;
            cnt_split    <= '0;
            cnt_redirect <= '0;
        end else begin
            if (w_hs &&  issue_dual) cnt_dual   <= cnt_dual + 1'b1;
            if (w_hs && !issue_dual) cnt_single <= cnt_single + 1'b1;
            if (w_spl_hs)            cnt_split  <= cnt_split + 1'b1;
            if (redirect)            cnt_redirect <= cnt_redirect + 1'b1;
        end
    end
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, sch_instr2[127:64]};
`else
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, sch_instr2[127:64], CNT_W[0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_dispatch_ctrl
// Purpose  : Directed self-checking bench for dispatch_ctrl. A small pair
//            scheduler model closes the loop from sch_fetch_data back to
//            the sch_* inputs.
// Options  : DISPATCH_STATS_EN - also checks the statistics counters.
// Revision : 1.0 - initial release
//============================================================================
module tb_dispatch_ctrl;

    localparam int c_cnt_w = 32;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         fetch_valid;
    logic [127:0] fetch_data;
    logic         fetch_ready;
    logic [127:0] sch_fetch_data;
    logic [127:0] sch_instr1;
    logic [127:0] sch_instr2;
    logic         sch_write1;
    logic         sch_write2;
    logic         sch_jal;
    logic [31:0]  sch_jal_addr;
    logic         issue_valid;
    logic         issue_ready;
    logic [127:0] issue_data;
    logic         issue_dual;
    logic         redirect;
    logic [31:0]  redirect_pc;
`ifdef DISPATCH_STATS_EN
    logic [c_cnt_w-1:0] cnt_dual, cnt_single, cnt_split, cnt_redirect;
`endif

    int errors = 0;
    int checks = 0;

    dispatch_ctrl #(.BUBBLE_CYC(2), .CNT_W(c_cnt_w)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .fetch_valid    (fetch_valid),
        .fetch_data     (fetch_data),
        .fetch_ready    (fetch_ready),
        .sch_fetch_data (sch_fetch_data),
        .sch_instr1     (sch_instr1),
        .sch_instr2     (sch_instr2),
        .sch_write1     (sch_write1),
        .sch_write2     (sch_write2),
        .sch_jal        (sch_jal),
        .sch_jal_addr   (sch_jal_addr),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_data     (issue_data),
        .issue_dual     (issue_dual),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
`ifdef DISPATCH_STATS_EN
        ,
        .cnt_dual       (cnt_dual),
        .cnt_single     (cnt_single),
        .cnt_split      (cnt_split),
        .cnt_redirect   (cnt_redirect)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scheduler model ----------------
    logic [31:0] m_pc0, m_ins0, m_pc1, m_ins1;
    logic [6:0]  m_opc0, m_opc1;
    logic        m_raw, m_mem, m_use_rs2, m_wr0;
    assign m_pc0  = sch_fetch_data[31:0];
    assign m_ins0 = sch_fetch_data[63:32];
    assign m_pc1  = sch_fetch_data[95:64];
    assign m_ins1 = sch_fetch_data[127:96];
    assign m_opc0 = m_ins0[6:0];
    assign m_opc1 = m_ins1[6:0];

    function automatic logic [31:0] jimm(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    always_comb begin
        sch_instr1   = 128'd0;
        sch_instr2   = 128'd0;
        sch_write1   = 1'b0;
        sch_write2   = 1'b0;
        sch_jal      = 1'b0;
        sch_jal_addr = 32'd0;
        m_wr0     = (m_ins0[11:7] != 5'd0) && (m_opc0 != 7'h23) && (m_opc0 != 7'h63);
        m_use_rs2 = (m_opc1 == 7'h33) || (m_opc1 == 7'h23) || (m_opc1 == 7'h63);
        m_raw     = m_wr0 && ((m_ins1[19:15] == m_ins0[11:7]) ||
                              (m_use_rs2 && (m_ins1[24:20] == m_ins0[11:7])));
        m_mem     = ((m_opc0 == 7'h03) || (m_opc0 == 7'h23)) &&
                    ((m_opc1 == 7'h03) || (m_opc1 == 7'h23));
        if (m_opc0 == 7'h6F) begin
            sch_jal      = 1'b1;
            sch_jal_addr = m_pc0 + jimm(m_ins0);
        end else if (m_opc1 == 7'h6F) begin
            sch_jal      = 1'b1;
            sch_write1   = 1'b1;
            sch_instr1   = {64'd0, m_ins0, m_pc0};
            sch_jal_addr = m_pc1 + jimm(m_ins1);
        end else if (m_raw || m_mem) begin
            sch_write1 = 1'b1;
            sch_write2 = 1'b1;
            sch_instr1 = {64'd0, m_ins0, m_pc0};
            sch_instr2 = {64'd0, m_ins1, m_pc1};
        end else begin
            sch_write1 = 1'b1;
            sch_instr1 = {m_ins1, m_pc1, m_ins0, m_pc0};
        end
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a pair in EMPTY and let it be accepted.
    task automatic load_pair(input logic [31:0] pc0, input logic [31:0] i0,
                             input logic [31:0] pc1, input logic [31:0] i1);
        fetch_valid = 1'b1;
        fetch_data  = {i1, pc1, i0, pc0};
        step();
        fetch_valid = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; fetch_data = '0; issue_ready = 1'b0;
        #12;
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL reset_fetch_ready got=%b exp=0", fetch_ready); end
        checks++; if (issue_valid !== 1'b0 || issue_dual !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL reset_outputs got v=%b d=%b r=%b exp 0", issue_valid, issue_dual, redirect); end
        checks++; if (issue_data !== 128'd0 || redirect_pc !== 32'd0 || sch_fetch_data !== 128'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", issue_data); end
        rst_n = 1'b1;
        step();
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL empty_fetch_ready got=%b exp=1", fetch_ready); end
    endtask

    task automatic test_dual();
        issue_ready = 1'b1;
        load_pair(32'h100, 32'h00100093, 32'h104, 32'h00300193);
        checks++; if (issue_valid !== 1'b1 || issue_dual !== 1'b1) begin errors++; $display("FAIL dual_valid got v=%b d=%b exp 1 1", issue_valid, issue_dual); end
        checks++; if (issue_data !== {32'h00300193, 32'h104, 32'h00100093, 32'h100}) begin errors++; $display("FAIL dual_data got=%h", issue_data); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL dual_fetch_ready got=%b exp=1", fetch_ready); end
        step();
        checks++; if (issue_valid !== 1'b0 || fetch_ready !== 1'b1) begin errors++; $display("FAIL dual_empty got v=%b fr=%b exp 0 1", issue_valid, fetch_ready); end
    endtask

    task automatic test_raw();
        issue_ready = 1'b1;
        load_pair(32'h100, 32'h00100093, 32'h104, 32'h00108133);
        checks++; if (issue_valid !== 1'b1 || issue_dual !== 1'b0 || issue_data !== {64'd0, 32'h00100093, 32'h100}) begin errors++; $display("FAIL raw_first got v=%b d=%b data=%h", issue_valid, issue_dual, issue_data); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL raw_first_ready got=%b exp=0", fetch_ready); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_dual !== 1'b0 || issue_data !== {64'd0, 32'h00108133, 32'h104}) begin errors++; $display("FAIL raw_second got v=%b d=%b data=%h", issue_valid, issue_dual, issue_data); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL raw_second_ready got=%b exp=1", fetch_ready); end
        step();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL raw_done got=%b exp=0", issue_valid); end
    endtask

    task automatic test_ldst();
        issue_ready = 1'b1;
        load_pair(32'h300, 32'h00002283, 32'h304, 32'h00002223);
        checks++; if (issue_valid !== 1'b1 || issue_dual !== 1'b0 || issue_data !== {64'd0, 32'h00002283, 32'h300}) begin errors++; $display("FAIL ldst_first got data=%h", issue_data); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_data !== {64'd0, 32'h00002223, 32'h304}) begin errors++; $display("FAIL ldst_second got data=%h", issue_data); end
        step();
`ifdef DISPATCH_STATS_EN
        checks++; if (cnt_split !== 32'd2) begin errors++; $display("FAIL ldst_cnt_split got=%0d exp=2", cnt_split); end
`endif
    endtask

    task automatic test_jal_slot0();
        issue_ready = 1'b1;
        load_pair(32'h200, 32'h0080006F, 32'h204, 32'h00300193);
        checks++; if (issue_valid !== 1'b0 || redirect !== 1'b1 || redirect_pc !== 32'h208) begin errors++; $display("FAIL jal1_redirect got v=%b r=%b pc=%h exp 0 1 208", issue_valid, redirect, redirect_pc); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL jal1_ready got=%b exp=0", fetch_ready); end
        // wrong-path fetch offered throughout the bubble
        fetch_valid = 1'b1;
        fetch_data  = {32'h00500293, 32'h20C, 32'h00400213, 32'h208};
        step();
        checks++; if (redirect !== 1'b0 || redirect_pc !== 32'd0 || fetch_ready !== 1'b0) begin errors++; $display("FAIL jal1_bubble1 got r=%b pc=%h fr=%b", redirect, redirect_pc, fetch_ready); end
        step();
        checks++; if (fetch_ready !== 1'b0 || issue_valid !== 1'b0) begin errors++; $display("FAIL jal1_bubble2 got fr=%b v=%b exp 0 0", fetch_ready, issue_valid); end
        checks++; if (sch_fetch_data !== {32'h00300193, 32'h204, 32'h0080006F, 32'h200}) begin errors++; $display("FAIL jal1_hold got=%h", sch_fetch_data); end
        fetch_valid = 1'b0;
        step();
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL jal1_bubble_end got=%b exp=1", fetch_ready); end
    endtask

    task automatic test_jal_slot1_stall();
        issue_ready = 1'b0;
        load_pair(32'h200, 32'h00100093, 32'h204, 32'h0080006F);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (issue_valid !== 1'b1 || issue_dual !== 1'b0 || issue_data !== {64'd0, 32'h00100093, 32'h200} || redirect !== 1'b0) begin
                errors++; $display("FAIL jal2_stall%0d got v=%b d=%b r=%b data=%h", i, issue_valid, issue_dual, redirect, issue_data);
            end
            step();
        end
        issue_ready = 1'b1;
        #1;
        checks++; if (issue_valid !== 1'b1 || redirect !== 1'b1 || redirect_pc !== 32'h20C) begin errors++; $display("FAIL jal2_handshake got v=%b r=%b pc=%h exp 1 1 20c", issue_valid, redirect, redirect_pc); end
        step();
        checks++; if (issue_valid !== 1'b0 || redirect !== 1'b0 || fetch_ready !== 1'b0) begin errors++; $display("FAIL jal2_bubble got v=%b r=%b fr=%b", issue_valid, redirect, fetch_ready); end
        step();
        step();
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL jal2_bubble_end got=%b exp=1", fetch_ready); end
    endtask

    task automatic test_flush();
        issue_ready = 1'b1;
        load_pair(32'h100, 32'h00100093, 32'h104, 32'h00108133);
        step();
        issue_ready = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_data !== {64'd0, 32'h00108133, 32'h104}) begin errors++; $display("FAIL flush_split_hold got v=%b data=%h", issue_valid, issue_data); end
        step();
        flush = 1'b1; issue_ready = 1'b1;
        #1;
        checks++; if (issue_valid !== 1'b0 || fetch_ready !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL flush_gate got v=%b fr=%b r=%b exp 0 0 0", issue_valid, fetch_ready, redirect); end
        step();
        flush = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0 || fetch_ready !== 1'b1 || sch_fetch_data !== 128'd0) begin errors++; $display("FAIL flush_empty got v=%b fr=%b hold=%h", issue_valid, fetch_ready, sch_fetch_data); end
    endtask

    task automatic test_back_to_back();
        issue_ready = 1'b1;
        load_pair(32'h400, 32'h00100093, 32'h404, 32'h00300193);
        fetch_valid = 1'b1;
        fetch_data  = {32'h00700393, 32'h40C, 32'h00500293, 32'h408};
        #1;
        checks++; if (fetch_ready !== 1'b1 || issue_dual !== 1'b1) begin errors++; $display("FAIL b2b_ready got fr=%b d=%b exp 1 1", fetch_ready, issue_dual); end
        step();
        fetch_valid = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_data !== {32'h00700393, 32'h40C, 32'h00500293, 32'h408}) begin errors++; $display("FAIL b2b_second got v=%b data=%h", issue_valid, issue_data); end
        step();
        checks++; if (issue_valid !== 1'b0 || fetch_ready !== 1'b1) begin errors++; $display("FAIL b2b_done got v=%b fr=%b", issue_valid, fetch_ready); end
`ifdef DISPATCH_STATS_EN
        checks++; if (cnt_dual !== 32'd3 || cnt_single !== 32'd6 || cnt_split !== 32'd3 || cnt_redirect !== 32'd2) begin
            errors++; $display("FAIL stats got d=%0d s=%0d sp=%0d r=%0d exp 3 6 3 2", cnt_dual, cnt_single, cnt_split, cnt_redirect);
        end
`endif
    endtask

    task automatic test_async_reset();
        issue_ready = 1'b0;
        load_pair(32'h500, 32'h00100093, 32'h504, 32'h00300193);
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got=%b exp=1", issue_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0 || fetch_ready !== 1'b0 || sch_fetch_data !== 128'd0 || issue_data !== 128'd0) begin
            errors++; $display("FAIL areset got v=%b fr=%b hold=%h", issue_valid, fetch_ready, sch_fetch_data);
        end
        #3;
        rst_n = 1'b1;
        step();
        checks++; if (fetch_ready !== 1'b1 || issue_valid !== 1'b0) begin errors++; $display("FAIL areset_after got fr=%b v=%b", fetch_ready, issue_valid); end
    endtask

    initial begin
        test_reset();
        test_dual();
        test_raw();
        test_ldst();
        test_jal_slot0();
        test_jal_slot1_stall();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
